axi4_lite_manager: RTL and testbench



---
 rtl/axi4_lite_manager.sv | 192 +++++++++++++++++++
 tb/tb_axi4_lite_manager.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_manager.sv
// Purpose : single-outstanding AXI4 manager; one cmd -> one single-beat (LEN=0, INCR, full-width) write or read -> one rsp.
// Latency : cmd accept -> AW/W or AR valid next cycle; rsp_valid the cycle after the B/R handshake (4 cycles best case).
// Backpr. : cmd_ready only in IDLE; rsp held stable until rsp_ready; AXI valids held stable until their handshakes.
// Ports   : ACLK/ARESET (async active-high); cmd_* command stream in; rsp_* response stream out;
//           AW/W/B/AR/R AXI4 manager channels (uppercase AXI names).
module axi4_lite_manager #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    // command stream
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    // response stream
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [ID_W-1:0]     rsp_id,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [1:0]          rsp_resp,
    output logic                rsp_proto_err,
    // write address channel
    output logic [ID_W-1:0]     AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    // write data channel
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    // write response channel
    input  logic [ID_W-1:0]     BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    // read address channel
    output logic [ID_W-1:0]     ARID,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [7:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    // read data channel
    input  logic [ID_W-1:0]     RID,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);

    localparam int         STRB_W   = DATA_W / 8;
    localparam logic [2:0] FULL_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic              aw_done, w_done;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    // Constant transfer attributes are held in flops so every AXI payload reads 0 out of reset.
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              wlast_q;

    logic cmd_hs, aw_hs, w_hs, b_hs, r_hs;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign b_hs   = BVALID & BREADY;
    assign r_hs   = RVALID & RREADY;

    // state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_write ? WR_REQ : RD_REQ;
            // AW and W may complete in either order or together; a flag or a live handshake counts.
            WR_REQ:  if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = WR_RESP;
            WR_RESP: if (BVALID) state_nxt = RSP;
            RD_REQ:  if (ARREADY) state_nxt = RD_RESP;
            RD_RESP: if (RVALID) state_nxt = RSP;
            RSP:     if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output decode: only state and registered flags, never a live input
    always_comb begin
        // ARESET gating keeps cmd_ready low while reset is held even though state already reads IDLE
        cmd_ready = (state == IDLE) & ~ARESET;
        AWVALID   = (state == WR_REQ) & ~aw_done;
        WVALID    = (state == WR_REQ) & ~w_done;
        BREADY    = (state == WR_RESP);
        ARVALID   = (state == RD_REQ);
        RREADY    = (state == RD_RESP);
        rsp_valid = (state == RSP);
    end

    // command capture, channel-done flags and response capture
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            id_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            wlast_q       <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_id        <= '0;
            rsp_data      <= '0;
            rsp_resp      <= '0;
            rsp_proto_err <= 1'b0;
        end else begin
            if (cmd_hs) begin
                id_q    <= cmd_id;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                size_q  <= FULL_SIZE;
                burst_q <= 2'b01;
                wlast_q <= 1'b1;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (b_hs) begin
                rsp_write     <= 1'b1;
                rsp_id        <= BID;
                rsp_data      <= '0;
                rsp_resp      <= BRESP;
                rsp_proto_err <= (BID != id_q);
            end else if (r_hs) begin
                rsp_write     <= 1'b0;
                rsp_id        <= RID;
                rsp_data      <= RDATA;
                rsp_resp      <= RRESP;
                rsp_proto_err <= (RID != id_q) | ~RLAST;
            end
        end
    end

    assign AWID    = id_q;
    assign AWADDR  = addr_q;
    assign AWLEN   = 8'd0;
    assign AWSIZE  = size_q;
    assign AWBURST = burst_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = wlast_q;
    assign ARID    = id_q;
    assign ARADDR  = addr_q;
    assign ARLEN   = 8'd0;
    assign ARSIZE  = size_q;
    assign ARBURST = burst_q;

endmodule

// File: tb/tb_axi4_lite_manager.sv
// Purpose : self-checking bench for axi4_lite_manager with a behavioural AXI subordinate memory and rsp scoreboard.
// Latency : n/a (bench).
// Backpr. : bench drives rsp_ready and subordinate ready delays to exercise stalls.
module tb_axi4_lite_manager;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ID_W-1:0]   cmd_id;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [7:0]        cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_write, rsp_proto_err;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_resp;
    logic [ID_W-1:0]   AWID, BID, ARID, RID;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [7:0]        AWLEN, ARLEN;
    logic [2:0]        AWSIZE, ARSIZE;
    logic [1:0]        AWBURST, ARBURST, BRESP, RRESP;
    logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [7:0]        WSTRB;

    always #5 ACLK = ~ACLK;

    axi4_lite_manager #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_proto_err(rsp_proto_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic              w;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              perr;
    } rsp_t;

    rsp_t              sb[$];
    logic [DATA_W-1:0] ref_mem [512];
    int                pushed = 0;

    // ---------------- subordinate controls / state ----------------
    logic [DATA_W-1:0] sub_mem [512];
    int   aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
    bit   rid_force = 0, rlast_zero = 0;
    bit   aw_got, w_got, ar_got, b_hs, r_hs;
    logic [ADDR_W-1:0] s_awaddr, s_araddr;
    logic [ID_W-1:0]   s_awid, s_arid;
    logic [7:0]        s_awlen, s_arlen;
    logic [2:0]        s_awsize, s_arsize;
    logic [1:0]        s_awburst, s_arburst;
    logic [DATA_W-1:0] s_wdata;
    logic [7:0]        s_wstrb;
    logic              s_wlast;

    // subordinate: all drives change on the falling edge; a handshake seen here completes at the next rising edge
    initial begin
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        BID = '0; BRESP = '0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0; aw_cnt = 0; w_cnt = 0;
            end else begin
                if (b_hs) BVALID = 0;
                if (r_hs) RVALID = 0;
                if (aw_got && w_got && !BVALID) begin
                    if (s_awaddr < 32'h1000) begin
                        for (int b = 0; b < 8; b++)
                            if (s_wstrb[b]) sub_mem[s_awaddr[11:3]][b*8 +: 8] = s_wdata[b*8 +: 8];
                        BRESP = 2'b00;
                    end else BRESP = 2'b10;
                    BID = s_awid; BVALID = 1; aw_got = 0; w_got = 0;
                end
                if (ar_got && !RVALID) begin
                    RID   = rid_force ? 4'd7 : s_arid;
                    RDATA = (s_araddr < 32'h1000) ? sub_mem[s_araddr[11:3]] : '0;
                    RRESP = (s_araddr < 32'h1000) ? 2'b00 : 2'b10;
                    RLAST = !rlast_zero;
                    RVALID = 1; ar_got = 0;
                end
                AWREADY = AWVALID && !aw_got && (aw_cnt >= aw_delay);
                if (AWVALID && !aw_got) aw_cnt++;
                WREADY = WVALID && !w_got && (w_cnt >= w_delay);
                if (WVALID && !w_got) w_cnt++;
                ARREADY = ARVALID && !ar_got;
                if (AWVALID && AWREADY) begin
                    s_awaddr = AWADDR; s_awid = AWID; s_awlen = AWLEN; s_awsize = AWSIZE;
                    s_awburst = AWBURST; aw_got = 1; aw_cnt = 0;
                end
                if (WVALID && WREADY) begin
                    s_wdata = WDATA; s_wstrb = WSTRB; s_wlast = WLAST; w_got = 1; w_cnt = 0;
                end
                if (ARVALID && ARREADY) begin
                    s_araddr = ARADDR; s_arid = ARID; s_arlen = ARLEN; s_arsize = ARSIZE;
                    s_arburst = ARBURST; ar_got = 1;
                end
                b_hs = BVALID && BREADY;
                r_hs = RVALID && RREADY;
            end
        end
    end

    // ---------------- monitor ----------------
    int   aw_vcyc = 0, w_vcyc = 0, aw_unstable = 0, rdy_bad = 0, rsp_cnt = 0;
    logic aw_prev_v = 0;
    logic [ADDR_W-1:0] aw_prev_addr;

    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                aw_prev_v = 0;
            end else begin
                if (AWVALID) aw_vcyc++;
                if (WVALID)  w_vcyc++;
                if (AWVALID && aw_prev_v && AWADDR !== aw_prev_addr) aw_unstable++;
                aw_prev_v = AWVALID; aw_prev_addr = AWADDR;
                if (BREADY && (AWVALID || WVALID || ARVALID || RREADY || rsp_valid || cmd_ready)) rdy_bad++;
                if (RREADY && (ARVALID || AWVALID || WVALID || rsp_valid || cmd_ready)) rdy_bad++;
                if (rsp_valid && rsp_ready) begin
                    rsp_cnt++;
                    if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
                    else begin
                        rsp_t e;
                        e = sb.pop_front();
                        chk("rsp_write", rsp_write, e.w);
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_resp", rsp_resp, e.resp);
                        chk("rsp_proto_err", rsp_proto_err, e.perr);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input logic w, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data, input logic [7:0] strb, input bit push,
                            output int waited);
        rsp_t e;
        @(posedge ACLK); #1;
        cmd_valid = 1; cmd_write = w; cmd_id = id; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        waited = 0;
        @(negedge ACLK);
        while (!cmd_ready && waited < 100) begin
            @(negedge ACLK);
            waited++;
        end
        chk("cmd_accept", cmd_ready, 1);
        if (push) begin
            e.w = w; e.perr = 0; e.resp = (addr < 32'h1000) ? 2'b00 : 2'b10;
            if (w) begin
                e.id = id; e.data = '0;
                if (addr < 32'h1000)
                    for (int b = 0; b < 8; b++)
                        if (strb[b]) ref_mem[addr[11:3]][b*8 +: 8] = data[b*8 +: 8];
            end else begin
                e.id   = rid_force ? 4'd7 : id;
                e.data = (addr < 32'h1000) ? ref_mem[addr[11:3]] : '0;
                e.perr = rid_force | rlast_zero;
            end
            sb.push_back(e);
            pushed++;
        end
        @(posedge ACLK); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge ACLK); #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic latency(output int cnt);
        cnt = 0;
        while (!rsp_valid && cnt < 50) begin
            @(posedge ACLK); #1;
            cnt++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w8, lat, base;
        logic [71:0] snap;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = '0; sub_mem[i] = '0;
        end
        ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_id = '0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1;

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 0);
        chk("rst_rsp", {rsp_write, rsp_id, rsp_data, rsp_resp, rsp_proto_err}, 0);
        chk("rst_addr_pay", {AWADDR, AWID, ARADDR, ARID}, 0);
        chk("rst_data_pay", {WDATA, WSTRB}, 0);
        @(posedge ACLK); #1;
        ARESET = 0;
        #1 chk("rel_cmd_ready", cmd_ready, 1);

        // zero-wait write
        send_cmd(1, 4'd3, 32'h10, 64'h1122334455667788, 8'hFF, 1, w8);
        latency(lat);
        chk("wr_lat", lat, 2);
        wait_done();
        chk("aw_addr", s_awaddr, 32'h10);
        chk("aw_id", s_awid, 3);
        chk("aw_const", {s_awlen, s_awsize, s_awburst}, {8'd0, 3'd3, 2'b01});
        chk("w_last", s_wlast, 1);
        chk("sub_mem", sub_mem[2], 64'h1122334455667788);

        // read after write
        send_cmd(0, 4'd5, 32'h10, '0, '0, 1, w8);
        chk("b2b_accept", w8, 0);
        latency(lat);
        chk("rd_lat", lat, 2);
        wait_done();
        chk("ar_addr", s_araddr, 32'h10);
        chk("ar_id", s_arid, 5);
        chk("ar_const", {s_arlen, s_arsize, s_arburst}, {8'd0, 3'd3, 2'b01});

        // AWREADY late, WREADY immediate
        aw_vcyc = 0; w_vcyc = 0; base = rsp_cnt; aw_delay = 3;
        send_cmd(1, 4'd2, 32'h18, 64'hA5A5_5A5A_0F0F_F0F0, 8'h0F, 1, w8);
        wait_done();
        aw_delay = 0;
        chk("stag_aw_cycles", aw_vcyc, 4);
        chk("stag_w_cycles", w_vcyc, 1);
        chk("stag_rsp_count", rsp_cnt - base, 1);

        // WREADY late, AWREADY immediate
        aw_vcyc = 0; w_vcyc = 0; w_delay = 2;
        send_cmd(1, 4'd9, 32'h20, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1, w8);
        wait_done();
        w_delay = 0;
        chk("stag2_aw_cycles", aw_vcyc, 1);
        chk("stag2_w_cycles", w_vcyc, 3);

        // partial-strobe readback and out-of-range accesses
        send_cmd(0, 4'd2, 32'h18, '0, '0, 1, w8);
        wait_done();
        send_cmd(0, 4'd6, 32'h2000, '0, '0, 1, w8);
        wait_done();
        send_cmd(1, 4'd1, 32'h3000, 64'h1, 8'hFF, 1, w8);
        wait_done();

        // protocol errors: wrong RID, then RLAST low
        rid_force = 1;
        send_cmd(0, 4'd5, 32'h10, '0, '0, 1, w8);
        wait_done();
        rid_force = 0; rlast_zero = 1;
        send_cmd(0, 4'd1, 32'h20, '0, '0, 1, w8);
        wait_done();
        rlast_zero = 0;

        // response backpressure
        rsp_ready = 0;
        send_cmd(0, 4'd4, 32'h10, '0, '0, 1, w8);
        latency(lat);
        chk("bp_rsp_valid", rsp_valid, 1);
        snap = {rsp_write, rsp_id, rsp_data, rsp_resp, rsp_proto_err};
        for (int i = 0; i < 5; i++) begin
            @(posedge ACLK); #1;
            chk("bp_rsp_stable", {rsp_valid, rsp_write, rsp_id, rsp_data, rsp_resp, rsp_proto_err}, {1'b1, snap});
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_no_req", {AWVALID, ARVALID}, 0);
        end
        rsp_ready = 1;
        wait_done();

        // reset while AWVALID is up: abandoned write must not reach memory
        aw_delay = 10;
        send_cmd(1, 4'd8, 32'h10, 64'hFFFF_0000_FFFF_0000, 8'hFF, 0, w8);
        chk("mid_awvalid", AWVALID, 1);
        @(posedge ACLK); #2;
        ARESET = 1;
        #1;
        chk("mid_rst_valids", {AWVALID, WVALID}, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        @(posedge ACLK); #1;
        ARESET = 0; aw_delay = 0;
        #1 chk("mid_rel_cmd_ready", cmd_ready, 1);
        send_cmd(0, 4'd5, 32'h10, '0, '0, 1, w8);
        wait_done();

        repeat (3) @(posedge ACLK);
        #1;
        chk("aw_unstable", aw_unstable, 0);
        chk("ready_outside_state", rdy_bad, 0);
        chk("rsp_total", rsp_cnt, pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // absolute time guard so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
